// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a downstream JK flip-flop: buffers {op, count} commands,
// plays them out as registered J/K pairs and checks the flip-flop against a reference.
module jk_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [CNT_W-1:0]              cmd_cnt,
   output logic                          J,
   output logic                          K,
   input  logic                          q_obs,
   output logic                          q_exp,
   output logic                          mismatch,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   // state | meaning
   // IDLE  | J=K=0, waiting for a queued command
   // RUN   | J/K hold cur_op until rem reaches zero

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 2 + CNT_W;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [ENT_W-1:0]  head;
   logic [1:0]        head_op, cur_op;
   logic [CNT_W-1:0]  head_cnt, rem;
   logic              full, empty, push, pop;
   logic              j_nxt, k_nxt, done_nxt;

   assign full      = (fifo_count == CNT_FULL);
   assign empty     = (fifo_count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem[rd_ptr];
   assign head_op   = head[ENT_W-1 -: 2];
   assign head_cnt  = head[CNT_W-1:0];
   assign busy      = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (rem == '0) begin
               if (!empty) pop = 1'b1;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      j_nxt    = 1'b0;
      k_nxt    = 1'b0;
      done_nxt = 1'b0;
      if (pop)                    {j_nxt, k_nxt} = head_op;
      else if (state_nxt == RUN)  {j_nxt, k_nxt} = cur_op;
      if (state == RUN && state_nxt == IDLE) done_nxt = 1'b1;
   end

   // Storage needs no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_cnt};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + OCC_ONE;
            2'b01:   fifo_count <= fifo_count - OCC_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_op <= 2'b00;
         rem    <= '0;
         J      <= 1'b0;
         K      <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (pop) begin
            cur_op <= head_op;
            rem    <= head_cnt;
         end else if (state == RUN && rem != '0) begin
            rem    <= rem - REM_ONE;
         end
         J    <= j_nxt;
         K    <= k_nxt;
         done <= done_nxt;
      end
   end

   // Reference flip-flop and check both use the pre-edge J/K and q_obs.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_exp    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         case ({J, K})
            2'b01:   q_exp <= 1'b0;
            2'b10:   q_exp <= 1'b1;
            2'b11:   q_exp <= !q_exp;
            default: q_exp <= q_exp;
         endcase
         if (q_obs != q_exp) mismatch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: behavioural flip-flop downstream, a queue-based
// command model compared every cycle, and directed literal checks.
module tb_jk_cmd_sequencer;
   localparam int D  = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op = 2'b00;
   logic [CW-1:0] cmd_cnt = '0;
   logic          cmd_ready, J, K, q_obs, q_exp, mismatch, busy, done;
   logic [2:0]    fifo_count;
   logic          ffq;
   logic          inject = 1'b0;
   logic          cmp_en = 1'b0;
   logic          saw_full = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   jk_cmd_sequencer #(.FIFO_DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .J(J), .K(K), .q_obs(q_obs),
      .q_exp(q_exp), .mismatch(mismatch), .busy(busy), .done(done),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // Downstream JK flip-flop; inject forces a wrong observed Q.
   always @(posedge clk) begin
      if (reset) ffq <= 1'b0;
      else case ({J, K})
         2'b01:   ffq <= 1'b0;
         2'b10:   ffq <= 1'b1;
         2'b11:   ffq <= ~ffq;
         default: ffq <= ffq;
      endcase
   end
   assign q_obs = ffq ^ inject;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: pending commands in a queue, current command as cycles-left.
   typedef struct {logic [1:0] op; int cnt;} cmd_t;
   cmd_t mq[$];
   cmd_t mc;
   int   m_left = 0;
   bit   m_j = 0, m_k = 0, m_q = 0, m_mis = 0, m_done = 0, m_room;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_left = 0; m_j = 0; m_k = 0; m_q = 0; m_mis = 0; m_done = 0;
      end else begin
         m_room = (mq.size() < D);
         if (q_obs !== m_q) m_mis = 1;
         if (m_j && m_k)  m_q = !m_q;
         else if (m_j)    m_q = 1;
         else if (m_k)    m_q = 0;
         m_done = 0;
         if (m_left > 1) m_left--;
         else if (mq.size() > 0) begin
            mc = mq.pop_front();
            m_j = mc.op[1]; m_k = mc.op[0]; m_left = mc.cnt + 1;
         end else begin
            if (m_left == 1) m_done = 1;
            m_left = 0; m_j = 0; m_k = 0;
         end
         if (cmd_valid && m_room) begin
            mc.op = cmd_op; mc.cnt = int'(cmd_cnt);
            mq.push_back(mc);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("J", J, m_j);
         check("K", K, m_k);
         check("q_exp", q_exp, m_q);
         check("mismatch", mismatch, m_mis);
         check("busy", busy, m_left > 0);
         check("done", done, m_done);
         check("fifo_count", fifo_count, mq.size());
         check("cmd_ready", cmd_ready, mq.size() < D);
         if (!cmd_ready && fifo_count == 3'd4) saw_full = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [1:0] op, input int cnt);
      bit ok;
      ok = 0;
      cmd_op = op;
      cmd_cnt = CW'(cnt);
      cmd_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (cmd_ready) begin ok = 1; break; end
         tick();
      end
      check("push_accept", ok, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      tick(); tick();
      reset = 1'b0;
      cmp_en = 1'b1;
      check("rst_J", J, 0);
      check("rst_K", K, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_count", fifo_count, 0);
      check("rst_busy", busy, 0);

      // SET cnt=0
      push(2'b10, 0);
      tick();
      check("set_J", J, 1);
      check("set_K", K, 0);
      check("set_busy", busy, 1);
      tick();
      check("set_J_off", J, 0);
      check("set_qexp", q_exp, 1);
      check("set_q", q_obs, 1);
      check("set_done", done, 1);
      check("set_mis", mismatch, 0);
      tick();
      check("set_done_off", done, 0);

      // TOGGLE cnt=3 from Q=0
      do_reset();
      push(2'b11, 3);
      tick();
      check("tog_JK", {J, K}, 2'b11);
      tick(); check("tog_q1", q_exp, 1); check("tog_busy1", busy, 1);
      tick(); check("tog_q2", q_exp, 0); check("tog_busy2", busy, 1);
      tick(); check("tog_q3", q_exp, 1); check("tog_busy3", busy, 1);
      tick(); check("tog_q4", q_exp, 0); check("tog_obs4", q_obs, 0);
      check("tog_busy_end", busy, 0); check("tog_done", done, 1);

      // RESET1, SET0, HOLD2 back to back
      tick();
      push(2'b01, 1);
      push(2'b10, 0);
      push(2'b00, 2);
      check("b2b_count", fifo_count, 2);
      check("b2b_JK3", {J, K}, 2'b01);
      tick(); check("b2b_JK4", {J, K}, 2'b10); check("b2b_nodone4", done, 0);
      tick(); check("b2b_JK5", {J, K}, 2'b00); check("b2b_busy5", busy, 1);
      tick(); check("b2b_busy6", busy, 1); check("b2b_nodone6", done, 0);
      tick(); check("b2b_busy7", busy, 1);
      tick(); check("b2b_busy8", busy, 0); check("b2b_done8", done, 1);
      tick(); check("b2b_done9", done, 0);

      // Long TOGGLE with six more queued behind it
      push(2'b11, 15);
      push(2'b10, 1);
      push(2'b01, 0);
      push(2'b11, 2);
      push(2'b00, 0);
      push(2'b10, 3);
      push(2'b11, 1);
      for (int i = 0; i < 300; i++) begin
         if (!busy && fifo_count == 0) break;
         tick();
      end
      check("drain_idle", busy, 0);
      check("saw_full", saw_full, 1);

      // Injected observation fault
      do_reset();
      check("inj_qexp0", q_exp, 0);
      inject = 1'b1;
      tick();
      inject = 1'b0;
      check("inj_mis", mismatch, 1);
      tick(); tick(); tick();
      check("inj_sticky", mismatch, 1);
      do_reset();
      check("inj_cleared", mismatch, 0);

      // Reset during TOGGLE cnt=7 with two queued
      push(2'b11, 7);
      push(2'b10, 0);
      push(2'b01, 0);
      check("abort_pre_count", fifo_count, 2);
      tick(); tick();
      do_reset();
      check("abort_JK", {J, K}, 2'b00);
      check("abort_count", fifo_count, 0);
      check("abort_qexp", q_exp, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      tick(); check("abort_nodone", done, 0);
      push(2'b10, 0);
      tick(); check("post_J", J, 1);
      tick(); check("post_qexp", q_exp, 1); check("post_done", done, 1);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream stimulus stage for the SR-based JK flip-flop (ports clk, reset, J, K, Q).
- Accepts encoded JK commands (operation plus repeat count) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the flip-flop's J/K inputs, one registered pair per clock.
- Runs a reference JK model on the same J/K and flags any divergence from the flip-flop's observed Q with a sticky mismatch flag.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- CNT_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  rising-edge clock, shared with the downstream flip-flop.
- reset  input  1  synchronous, active-high; shared with the downstream flip-flop.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_op  input  2  00 HOLD (J0 K0), 01 RESET (J0 K1), 10 SET (J1 K0), 11 TOGGLE (J1 K1).
- cmd_cnt  input  CNT_W  apply op for cmd_cnt+1 consecutive cycles.
- J  output  1  registered J to the flip-flop.
- K  output  1  registered K to the flip-flop.
- q_obs  input  1  Q from the flip-flop.
- q_exp  output  1  registered model Q.
- mismatch  output  1  sticky; set on any q_obs != q_exp.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the last queued command completes.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (clk edge with reset=1):
  - FIFO flushed, fifo_count=0, state IDLE.
  - J=0, K=0, q_exp=0, mismatch=0, busy=0, done=0, cmd_ready=1.
  - Reset mid-command aborts the command; remaining count and queued entries are discarded.
- Push: when cmd_valid && cmd_ready at an edge, {cmd_op, cmd_cnt} is written to the FIFO.
  - cmd_ready=0 when full, so there is no push on full.
  - No bypass: an entry pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states: IDLE and RUN.
  - IDLE:
    - J=K=0, busy=0.
    - If FIFO non-empty at an edge: pop, load cur_op, load rem=cmd_cnt, drive J/K from op, go RUN.
  - RUN:
    - J/K hold cur_op; each edge, rem decrements.
    - At the edge where rem==0, if FIFO non-empty: pop the next command and load it the same edge (back-to-back, no bubble, stay in RUN).
    - Otherwise: J=K=0, go IDLE, pulse done for one cycle.
  - Simultaneous push and pop in one edge is legal; fifo_count is unchanged.
- Latency:
  - Command accepted at edge t appears on J/K after edge t+1 (empty FIFO, IDLE).
  - The flip-flop and q_exp reflect it after edge t+2.
  - A command with count c occupies exactly c+1 cycles of J/K.
- Model: at every non-reset edge, q_exp updates from the current registered J/K:
  - 00 hold
  - 01 -> 0
  - 10 -> 1
  - 11 -> !q_exp
- Check:
  - At every non-reset edge, if q_obs != q_exp, mismatch <= 1.
  - mismatch stays 1 until reset.
  - The comparison uses the pre-edge registered values of both, which are aligned because both are reset together.
- FIFO pointers wrap modulo FIFO_DEPTH; full is fifo_count==FIFO_DEPTH and empty is fifo_count==0.

Test Plan:
- Reset, then push SET cnt=0 -> J=1,K=0 for exactly 1 cycle starting 2 edges after push; q_exp=Q=1; done pulse; mismatch=0.
- Push TOGGLE cnt=3 -> J=K=1 for 4 cycles; Q sequence 1,0,1,0 from a start of 0; q_exp tracks; busy high 4 cycles.
- Push RESET cnt=1, SET cnt=0, HOLD cnt=2 back-to-back -> J/K pairs 01,01,10,00,00,00 with no gaps; single done at end; fifo_count peaks at 2 or 3.
- Hold cmd_valid=1 with 6 commands while the first runs cnt=15 -> cmd_ready drops once fifo_count=4; no entry lost; all execute in order.
- Force q_obs to 1 while the model expects 0 for one cycle -> mismatch=1 and stays 1 after q_obs recovers; cleared only by reset.
- Assert reset during TOGGLE cnt=7 with 2 entries queued -> after the edge J=K=0, fifo_count=0, q_exp=0, busy=0; no done pulse; a subsequent SET runs normally.
